// File: rtl/pipe_mac.sv
// pipe_mac: (A+B)*(C+D) over a 3-stage globally stalled pipeline with
// per-sample product / accumulate / clear-and-load modes and a saturating result.
module pipe_mac #(
  parameter int unsigned N     = 10,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [N-1:0]     C,
  input  logic [N-1:0]     D,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] Y,
  output logic             sat,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned SW = N + 1;
  localparam int unsigned PW = 2 * N + 2;
  // Wide enough for acc + P without loss, whichever operand is wider.
  localparam int unsigned RW = ((PW > OUT_W) ? PW : OUT_W) + 1;

  localparam logic [1:0]    MODE_ACC  = 2'b01;
  localparam logic [1:0]    MODE_LOAD = 2'b10;
  localparam logic [RW-1:0] Y_MAX     = RW'({OUT_W{1'b1}});

  logic             adv;
  logic             s1_valid;
  logic [SW-1:0]    s1_ab;
  logic [SW-1:0]    s1_cd;
  logic [1:0]       s1_mode;
  logic             s2_valid;
  logic [PW-1:0]    s2_p;
  logic [1:0]       s2_mode;
  logic [OUT_W-1:0] acc;
  logic [RW-1:0]    r_full;
  logic             r_over;
  logic [OUT_W-1:0] y_next;

  // Global stall and S3 result / saturation.
  always_comb begin
    adv      = ~out_valid | out_ready;
    in_ready = adv;
    r_full   = (s2_mode == MODE_ACC) ? RW'(acc) + RW'(s2_p) : RW'(s2_p);
    r_over   = r_full > Y_MAX;
    y_next   = r_over ? {OUT_W{1'b1}} : r_full[OUT_W-1:0];
  end

  // S1: operand pair sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ab    <= '0;
      s1_cd    <= '0;
      s1_mode  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_ab    <= SW'(A) + SW'(B);
      s1_cd    <= SW'(C) + SW'(D);
      s1_mode  <= mode;
    end
  end

  // S2: product of the sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_mode  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_p     <= PW'(s1_ab) * PW'(s1_cd);
      s2_mode  <= s1_mode;
    end
  end

  // S3: output beat; Y/sat/acc only move on a valid sample, bubbles just drop out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Y         <= '0;
      sat       <= 1'b0;
      acc       <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        Y   <= y_next;
        sat <= r_over;
        if (s2_mode == MODE_ACC || s2_mode == MODE_LOAD) begin
          acc <= y_next;
        end
      end
    end
  end

  // Completed output handshakes, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_mac.sv
// Bench for pipe_mac: a 32-bit and a 16-bit (4-bit counter) instance share stimulus;
// directed table plus random traffic checked against an in-order queue model.
module tb_pipe_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [9:0]  A = '0, B = '0, C = '0, D = '0;
  logic [1:0]  mode = '0;

  logic        ir32, ov32, sat32;
  logic [31:0] y32;
  logic [15:0] cnt32;
  logic        ir16, ov16, sat16;
  logic [15:0] y16;
  logic [3:0]  cnt16;

  pipe_mac dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
    .A(A), .B(B), .C(C), .D(D), .mode(mode),
    .out_valid(ov32), .out_ready(out_ready), .Y(y32), .sat(sat32), .out_count(cnt32)
  );

  pipe_mac #(.N(10), .OUT_W(16), .CNT_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
    .A(A), .B(B), .C(C), .D(D), .mode(mode),
    .out_valid(ov16), .out_ready(out_ready), .Y(y16), .sat(sat16), .out_count(cnt16)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint y;
    bit     s;
  } exp_t;

  typedef struct {
    int     a, b, c, d, m;
    longint y32;
    bit     s32;
    longint y16;
    bit     s16;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endfunction

  // Reference: each accepted sample resolved in order against a running accumulator.
  function automatic exp_t mac(longint acc, longint p, int m, int w);
    exp_t   e;
    longint mx = (longint'(1) << w) - 1;
    longint r  = (m == 1) ? acc + p : p;
    e.s = (r > mx);
    e.y = e.s ? mx : r;
    return e;
  endfunction

  exp_t   q32[$], q16[$];
  longint acc32, acc16, cnt32_m, cnt16_m;
  bit     hold32, hold16, hs32, hs16;
  longint hy32, hy16;
  exp_t   me;
  longint mp;

  function automatic void clear_model();
    q32.delete();
    q16.delete();
    acc32 = 0; acc16 = 0; cnt32_m = 0; cnt16_m = 0;
    hold32 = 0; hold16 = 0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (hold32) begin
        chk("hold_valid32", longint'(ov32), 1);
        chk("hold_y32", longint'(y32), hy32);
        chk("hold_sat32", longint'(sat32), longint'(hs32));
      end
      if (hold16) begin
        chk("hold_valid16", longint'(ov16), 1);
        chk("hold_y16", longint'(y16), hy16);
        chk("hold_sat16", longint'(sat16), longint'(hs16));
      end
      chk("count32", longint'(cnt32), cnt32_m);
      chk("count16", longint'(cnt16), cnt16_m);
      chk("in_ready32", longint'(ir32), longint'(!ov32 || out_ready));
      chk("in_ready16", longint'(ir16), longint'(!ov16 || out_ready));
      if (ov32 && out_ready) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat32 actual=beat y=%0d required=no beat", y32);
        end else begin
          me = q32.pop_front();
          chk("y32", longint'(y32), me.y);
          chk("sat32", longint'(sat32), longint'(me.s));
          cnt32_m = (cnt32_m + 1) % 65536;
        end
      end
      if (ov16 && out_ready) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat16 actual=beat y=%0d required=no beat", y16);
        end else begin
          me = q16.pop_front();
          chk("y16", longint'(y16), me.y);
          chk("sat16", longint'(sat16), longint'(me.s));
          cnt16_m = (cnt16_m + 1) % 16;
        end
      end
      hold32 = ov32 && !out_ready; hy32 = longint'(y32); hs32 = sat32;
      hold16 = ov16 && !out_ready; hy16 = longint'(y16); hs16 = sat16;
      mp = (longint'(A) + longint'(B)) * (longint'(C) + longint'(D));
      if (in_valid && ir32) begin
        me = mac(acc32, mp, int'(mode), 32);
        q32.push_back(me);
        if (mode == 2'b01 || mode == 2'b10) acc32 = me.y;
      end
      if (in_valid && ir16) begin
        me = mac(acc16, mp, int'(mode), 16);
        q16.push_back(me);
        if (mode == 2'b01 || mode == 2'b10) acc16 = me.y;
      end
    end
  end

  task automatic drive(input bit v, input vec_t t);
    in_valid = v;
    A = 10'(t.a); B = 10'(t.b); C = 10'(t.c); D = 10'(t.d);
    mode = 2'(t.m);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_out(string nm, vec_t t);
    chk({nm, "_valid32"}, longint'(ov32), 1);
    chk({nm, "_y32"}, longint'(y32), t.y32);
    chk({nm, "_sat32"}, longint'(sat32), longint'(t.s32));
    chk({nm, "_valid16"}, longint'(ov16), 1);
    chk({nm, "_y16"}, longint'(y16), t.y16);
    chk({nm, "_sat16"}, longint'(sat16), longint'(t.s16));
  endtask

  vec_t v;
  int   k;

  initial begin
    tbl[0]  = '{5, 10, 15, 20, 0, 525, 0, 525, 0};
    tbl[1]  = '{4, 8, 12, 16, 0, 336, 0, 336, 0};
    tbl[2]  = '{3, 6, 9, 12, 0, 189, 0, 189, 0};
    tbl[3]  = '{6, 12, 18, 24, 0, 756, 0, 756, 0};
    tbl[4]  = '{8, 16, 24, 32, 0, 1344, 0, 1344, 0};
    tbl[5]  = '{5, 10, 15, 20, 2, 525, 0, 525, 0};
    tbl[6]  = '{4, 8, 12, 16, 1, 861, 0, 861, 0};
    tbl[7]  = '{3, 6, 9, 12, 1, 1050, 0, 1050, 0};
    tbl[8]  = '{1, 1, 1, 1, 2, 4, 0, 4, 0};
    tbl[9]  = '{1023, 1023, 1023, 1023, 0, 4186116, 0, 65535, 1};
    tbl[10] = '{1, 1, 1, 1, 2, 4, 0, 4, 0};
    tbl[11] = '{1, 1, 1, 1, 1, 8, 0, 8, 0};
    tbl[12] = '{1023, 1023, 1023, 1023, 1, 4186124, 0, 65535, 1};
    tbl[13] = '{1, 1, 1, 1, 1, 4186128, 0, 65535, 1};
    tbl[14] = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[15] = '{1, 2, 3, 4, 2, 21, 0, 21, 0};

    clear_model();
    apply_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_valid32", longint'(ov32), 0);
    chk("rst_y32", longint'(y32), 0);
    chk("rst_sat32", longint'(sat32), 0);
    chk("rst_valid16", longint'(ov16), 0);
    chk("rst_y16", longint'(y16), 0);
    chk("rst_ready32", longint'(ir32), 1);

    // Lone sample: visible on the 3rd edge counting the accepting one.
    @(posedge clk); #1 drive(1'b1, tbl[0]);
    @(negedge clk); chk("lat_pre", longint'(ov32), 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("lat_e1", longint'(ov32), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_e2", longint'(ov32), 0);
    @(posedge clk); #1;
    @(negedge clk); chk_out("lat_e3", tbl[0]);

    // Back-to-back stream of the remaining table entries.
    for (int j = 0; j < NV - 1 + 3; j++) begin
      @(posedge clk); #1;
      if (j < NV - 1) drive(1'b1, tbl[j + 1]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (j == 0) chk("lat_count32", longint'(cnt32), 1);
      if (j < NV - 1) chk("stream_ready", longint'(ir32), 1);
      if (j < 3) chk("stream_bubble", longint'(ov32), 0);
      else chk_out($sformatf("vec%0d", j - 2), tbl[j - 2]);
    end

    // Backpressure: out_ready low for 4 cycles from the first out_valid.
    apply_reset();
    k = 0;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      out_ready = !(j >= 3 && j <= 6);
      if (k < 5) drive(1'b1, tbl[k + 1]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (j >= 3 && j <= 6) begin
        chk("bp_ready", longint'(ir32), 0);
        chk("bp_valid", longint'(ov32), 1);
        chk("bp_y32", longint'(y32), 336);
      end
      if (in_valid && ir32) k++;
    end
    chk("bp_accepted", longint'(k), 5);
    chk("bp_count32", longint'(cnt32), 5);
    chk("bp_left32", longint'(q32.size()), 0);

    // Asynchronous reset with samples in flight.
    apply_reset();
    v = '{1023, 1023, 1023, 1023, 2, 0, 0, 0, 0};
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      if (j < 3) drive(1'b1, v);
      else in_valid = 1'b0;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    clear_model();
    #1;
    chk("mrst_valid32", longint'(ov32), 0);
    chk("mrst_y32", longint'(y32), 0);
    chk("mrst_count32", longint'(cnt32), 0);
    chk("mrst_valid16", longint'(ov16), 0);
    chk("mrst_y16", longint'(y16), 0);
    chk("mrst_sat16", longint'(sat16), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 drive(1'b1, '{1, 1, 1, 1, 1, 4, 0, 4, 0});
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); chk_out("mrst_acc", '{1, 1, 1, 1, 1, 4, 0, 4, 0});

    // Random traffic against the queue model.
    apply_reset();
    for (int j = 0; j < 600; j++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        A = 10'd1023; B = 10'd1023; C = 10'd1023; D = 10'd1023;
      end else begin
        A = 10'($urandom_range(0, 1023)); B = 10'($urandom_range(0, 1023));
        C = 10'($urandom_range(0, 63));   D = 10'($urandom_range(0, 63));
      end
      mode = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("drain_q32", longint'(q32.size()), 0);
    chk("drain_q16", longint'(q16.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
